// File: rtl/ks_decomp_stream.sv
// ks_decomp_stream: keyswitch input stage.
// Each 64-bit coefficient is rounded to its KS_L*KS_B_W most significant bits.
// The rounded value is then emitted as KS_L balanced signed base-2^KS_B_W digits,
// one digit per cycle, least-significant level first.
// Optional macro KS_DECOMP_OVF_CNT_EN adds a 16-bit saturating ovf_cnt output.
// It counts coefficients whose dropped final carry was 1.
//
// Handshake: a transfer happens on a rising edge where valid && ready.
// A valid that is not taken holds its payload stable.
// ready never depends combinationally on the same port's valid.
module ks_decomp_stream #(
  parameter int MOD_Q_W = 64,
  parameter int KS_L    = 8,
  parameter int KS_B_W  = 2,
  parameter int BLWE_K  = 2048,
  parameter int LVL_W   = (KS_L > 1) ? $clog2(KS_L) : 1
) (
  input  logic               clk,
  input  logic               s_rst,
  input  logic [MOD_Q_W-1:0] in_coef,
  input  logic               in_vld,
  output logic               in_rdy,
  output logic [KS_B_W-1:0]  out_digit,
  output logic [LVL_W-1:0]   out_level,
  output logic               out_last,
  output logic               out_vld,
  input  logic               out_rdy,
`ifdef KS_DECOMP_OVF_CNT_EN
  output logic [15:0]        ovf_cnt,
`endif
  output logic               dbg_state
);

  localparam int R     = KS_L * KS_B_W;
  localparam int CNT_W = $clog2(BLWE_K + 1);

  typedef enum logic {IDLE = 1'b0, DECOMP = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [R-1:0]       r_q;
  logic [LVL_W-1:0]   level_q;
  logic               carry_q;
  logic [CNT_W-1:0]   cnt_q;

  logic [R-1:0]       r_round;
  logic [KS_B_W:0]    d_ext;
  logic               carry_nxt;
  logic               hs;
  logic               final_hs;
  logic               in_acc;
  logic               lvl_top;

  // Round to R MSBs with the next bit as round-half-up; overflow wraps mod 2^R.
  always_comb begin
    r_round = in_coef[MOD_Q_W-1 -: R] + {{(R-1){1'b0}}, in_coef[MOD_Q_W-R-1]};
  end

  // Balanced digit for the current level: slice plus incoming carry, recentred.
  always_comb begin
    d_ext     = {1'b0, r_q[level_q*KS_B_W +: KS_B_W]} + {{KS_B_W{1'b0}}, carry_q};
    carry_nxt = (d_ext >= (KS_B_W+1)'(1 << (KS_B_W-1)));
  end

  // Output and handshake decode, all derived from registered state.
  always_comb begin
    lvl_top   = (level_q == LVL_W'(KS_L-1));
    out_vld   = (state_q == DECOMP);
    out_digit = out_vld ? d_ext[KS_B_W-1:0] : '0;
    out_level = level_q;
    out_last  = out_vld && lvl_top && (cnt_q == CNT_W'(BLWE_K));
    hs        = out_vld && out_rdy;
    final_hs  = hs && lvl_top;
    in_rdy    = !s_rst && ((state_q == IDLE) || final_hs);
    in_acc    = in_vld && in_rdy;
    dbg_state = state_q;
  end

  // Next-state logic: refill straight from the final digit when an input is waiting.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_acc) state_d = DECOMP;
      DECOMP:  if (final_hs && !in_acc) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (s_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Datapath: rounded value, level/carry walk and coefficient index.
  always_ff @(posedge clk) begin
    if (s_rst) begin
      r_q     <= '0;
      level_q <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      if (hs) begin
        level_q <= lvl_top ? '0 : level_q + LVL_W'(1);
        carry_q <= carry_nxt;
      end
      if (final_hs) begin
        cnt_q <= (cnt_q == CNT_W'(BLWE_K)) ? '0 : cnt_q + CNT_W'(1);
      end
      if (in_acc) begin
        r_q     <= r_round;
        level_q <= '0;
        carry_q <= 1'b0;
      end
    end
  end

`ifdef KS_DECOMP_OVF_CNT_EN
  // Saturating count of coefficients whose top-level carry fell off the end.
  always_ff @(posedge clk) begin
    if (s_rst) ovf_cnt <= '0;
    else if (final_hs && carry_nxt && (ovf_cnt != 16'hFFFF)) ovf_cnt <= ovf_cnt + 16'd1;
  end
`endif

endmodule
